// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Purpose  : Byte-serial UART transmitter. Accepts one byte per valid/ready
//            handshake and sends start + 8 data bits (LSB first) + optional
//            parity + stop, each bit held for CDIV clocks.
// Ports    : clk_i       - system clock, rising edge
//            rst_i       - asynchronous active-high reset
//            in_valid_i  - upstream FIFO has a byte on in_data_i
//            in_data_i   - byte to send, sampled only on a handshake
//            in_ready_o  - transmitter can accept a byte (IDLE only)
//            tx_o        - serial line, idle high, driven from a flop
//            busy_o      - a frame is in progress
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
  parameter int CDIV   = 4,  // clocks per bit, >= 2
  parameter int PARITY = 0   // 0 none, 1 odd, 2 even
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  generate
    if (CDIV < 2) begin : g_bad_cdiv
      $error("uart_tx_frame: CDIV must be >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
  endgenerate

  // Guard keeps the timer at least one bit wide while the error above fires.
  localparam int            TW       = (CDIV < 2) ? 1 : $clog2(CDIV);
  localparam logic [TW-1:0] BIT_LAST = TW'(CDIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]    state_q,  state_d;
  logic [TW-1:0] timer_q,  timer_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q,  shreg_d;
  logic          par_q,    par_d;
  logic          tx_q,     tx_d;

  logic hs;
  logic bit_end;

  assign hs      = in_valid_i & in_ready_o;
  assign bit_end = (timer_q == '0);

  // State register (also holds the datapath registers and the tx flop)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;

    if (state_q != S_IDLE && !bit_end) begin
      timer_d = timer_q - TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          state_d  = S_START;
          timer_d  = BIT_LAST;
          bitcnt_d = 3'd0;
          shreg_d  = in_data_i;
          // Parity taken from the byte as latched, before any shifting.
          par_d    = (PARITY == 1) ? ~^in_data_i : ^in_data_i;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          timer_d = BIT_LAST;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          timer_d = BIT_LAST;
          if (bitcnt_q == 3'd7) begin
            state_d  = (PARITY != 0) ? S_PAR : S_STOP;
            bitcnt_d = 3'd0;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
            shreg_d  = {1'b0, shreg_q[7:1]};
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_d = S_STOP;
          timer_d = BIT_LAST;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Output logic. tx is decoded from the next state so the registered line
  // changes on the same edge as the state it represents.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_IDLE:  tx_d = 1'b1;
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[0];
      S_PAR:   tx_d = par_q;
      S_STOP:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  assign in_ready_o = (state_q == S_IDLE);
  assign busy_o     = (state_q != S_IDLE);
  assign tx_o       = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Purpose  : Self-checking bench for uart_tx_frame. Three instances with
//            CDIV=4 cover PARITY 0, 1 and 2; expected line levels come from
//            a frame model built from the byte and the parity rule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

  localparam int CDIV = 4;

  logic       clk;
  logic       rst;
  logic [2:0] valid;
  logic [7:0] data [3];
  wire  [2:0] txw;
  wire  [2:0] rdy;
  wire  [2:0] bsy;

  int nchk = 0;
  int nerr = 0;
  int pops [3] = '{0, 0, 0};

  uart_tx_frame #(.CDIV(CDIV), .PARITY(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(valid[0]), .in_data_i(data[0]),
    .in_ready_o(rdy[0]), .tx_o(txw[0]), .busy_o(bsy[0]));
  uart_tx_frame #(.CDIV(CDIV), .PARITY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(valid[1]), .in_data_i(data[1]),
    .in_ready_o(rdy[1]), .tx_o(txw[1]), .busy_o(bsy[1]));
  uart_tx_frame #(.CDIV(CDIV), .PARITY(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(valid[2]), .in_data_i(data[2]),
    .in_ready_o(rdy[2]), .tx_o(txw[2]), .busy_o(bsy[2]));

  always #5 clk = ~clk;

  // FIFO pop counter: one per handshake edge
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (valid[i] && rdy[i]) pops[i]++;
    end
  end

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level for bit slot idx of a frame: 0 start, 1..8 data LSB first,
  // 9 parity (if enabled) else stop, then stop.
  function automatic logic model_bit(input logic [7:0] b, input int par, input int idx);
    int ones;
    ones = $countones(b);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && par == 1) return (ones % 2 == 0) ? 1'b1 : 1'b0;
    if (idx == 9 && par == 2) return (ones % 2 == 1) ? 1'b1 : 1'b0;
    return 1'b1;
  endfunction

  // Sends one byte on instance p and checks every cycle of the frame.
  // stall_c: cycle at which valid pulses mid-frame (-1 none).
  // abort_c: cycle at which reset is applied mid-frame (-1 none).
  task automatic send_frame(input int p, input logic [7:0] b, input int stall_c, input int abort_c);
    int f;
    int p0;
    f  = (p == 0) ? 10 : 11;
    p0 = pops[p];
    check(32'(rdy[p]), 1, "ready_before");
    valid[p] = 1'b1;
    data[p]  = b;
    @(negedge clk);
    data[p] = 8'($urandom);
    check(32'(rdy[p]), 0, "ready_after_hs");
    for (int c = 0; c < f * CDIV; c++) begin
      check(32'(txw[p]), 32'(model_bit(b, p, c / CDIV)), "tx_bit");
      check(32'(bsy[p]), 1, "busy_frame");
      if (c == abort_c) begin
        rst = 1'b1;
        #1;
        check(32'(txw[p]), 1, "abort_tx");
        check(32'(bsy[p]), 0, "abort_busy");
        check(32'(rdy[p]), 1, "abort_ready");
        valid[p] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check(32'(txw[p]), 1, "abort_tx_after");
        check(32'(pops[p]), 32'(p0 + 1), "abort_pops");
        return;
      end
      if (c == stall_c) begin
        check(32'(rdy[p]), 0, "stall_ready");
        data[p] = 8'($urandom);
      end
      valid[p] = (c == stall_c);
      @(negedge clk);
    end
    valid[p] = 1'b0;
    check(32'(txw[p]), 1, "tx_idle");
    check(32'(bsy[p]), 0, "busy_end");
    check(32'(rdy[p]), 1, "ready_end");
    check(32'(pops[p]), 32'(p0 + 1), "pops_frame");
  endtask

  initial begin
    logic [7:0] bb [3];
    logic       samp [123];
    int         hst [3];
    int         k;
    int         n;
    int         p0;
    logic       hs_pending;

    clk = 1'b0;
    rst = 1'b1;
    valid = 3'b000;
    for (int i = 0; i < 3; i++) data[i] = 8'h00;

    // Power-on reset state
    @(negedge clk);
    check(32'(txw), 32'h7, "por_tx");
    check(32'(rdy), 32'h7, "por_ready");
    check(32'(bsy), 32'h0, "por_busy");
    rst = 1'b0;
    @(negedge clk);

    // 1. Reset pulse while idle
    rst = 1'b1;
    #1;
    check(32'(txw), 32'h7, "rst_tx_during");
    check(32'(rdy), 32'h7, "rst_ready_during");
    check(32'(bsy), 32'h0, "rst_busy_during");
    @(negedge clk);
    rst = 1'b0;
    check(32'(txw), 32'h7, "rst_tx_after");
    check(32'(rdy), 32'h7, "rst_ready_after");
    check(32'(bsy), 32'h0, "rst_busy_after");
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check(32'(txw), 32'h7, "idle_tx_100");
    end

    // 2. Single byte 'A', no parity
    send_frame(0, 8'h41, -1, -1);

    // 3. Back-to-back with valid held high
    bb[0] = 8'h20; bb[1] = 8'h21; bb[2] = 8'h22;
    p0 = pops[0];
    k = 0;
    n = 0;
    valid[0] = 1'b1;
    data[0]  = bb[0];
    for (int cyc = 0; cyc < 300 && n < 123; cyc++) begin
      hs_pending = valid[0] & rdy[0];
      @(posedge clk);
      if (hs_pending && k < 3) begin
        hst[k] = cyc;
        k++;
      end
      @(negedge clk);
      if (hs_pending) begin
        if (k < 3) data[0] = bb[k];
        else valid[0] = 1'b0;
      end
      if (k >= 1) begin
        samp[n] = txw[0];
        n++;
      end
    end
    valid[0] = 1'b0;
    check(32'(k), 3, "b2b_handshakes");
    check(32'(n), 123, "b2b_samples");
    if (k == 3) begin
      check(32'(hst[1] - hst[0]), 41, "b2b_spacing_1");
      check(32'(hst[2] - hst[1]), 41, "b2b_spacing_2");
    end
    for (int j = 0; j < 3; j++) begin
      for (int c = 0; c < 41; c++) begin
        if (j * 41 + c < n)
          check(32'(samp[j*41+c]), 32'((c < 40) ? model_bit(bb[j], 0, c / CDIV) : 1'b1), "b2b_stream");
      end
    end
    check(32'(pops[0]), 32'(p0 + 3), "b2b_pops");

    // 4. Parity: 0x07 odd then even
    send_frame(1, 8'h07, -1, -1);
    send_frame(2, 8'h07, -1, -1);

    // 5. Reset during data bit 3 of 0x55, then a clean frame
    send_frame(0, 8'h55, -1, 4 * CDIV + 1);
    p0 = pops[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check(32'(txw[0]), 1, "post_abort_idle_tx");
    end
    check(32'(pops[0]), 32'(p0), "post_abort_no_pop");
    send_frame(0, 8'h7E, -1, -1);

    // 6. valid pulse while busy
    send_frame(0, 8'hA5, 10, -1);
    send_frame(1, 8'h3C, 30, -1);

    // Randomized frames on random instances
    for (int i = 0; i < 6; i++) begin
      send_frame(int'($urandom_range(2, 0)), 8'($urandom), -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
